rf_wb_arbiter: RTL
==================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, consecutive denied cycles before the debug requester is promoted to top priority.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 ld_valid / ld_rd / ld_data  input  1/5/32  load-unit writeback request, destination, data.
REQ-005 ld_ready  output  1  load request granted this cycle.
REQ-006 alu_valid / alu_rd / alu_data  input  1/5/32  ALU writeback request, destination, data.
REQ-007 alu_ready  output  1  ALU request granted this cycle.
REQ-008 dbg_valid / dbg_rd / dbg_data  input  1/5/32  debug writeback request, destination, data.
REQ-009 dbg_ready  output  1  debug request granted this cycle.
REQ-010 iss_valid / iss_rd  input  1/5  instruction issue marking iss_rd as pending writeback.
REQ-011 rs1 / rs2  input  5/5  source registers of the instruction in decode.
REQ-012 stall  output  1  decode must hold; a source register is pending.
REQ-013 we / wa / wd  output  1/5/32  registered register-file write enable, address, data.
REQ-014 busy  output  32  scoreboard; bit n set = register n has a pending writeback.

Function
REQ-015 A transfer occurs on a requester when its valid and ready are both high at a rising clk edge.
REQ-016 At most one ready is high per cycle; ready is combinational from the valids and the starvation state.
REQ-017 Default priority: ld > alu > dbg.
REQ-018 starve_cnt increments each cycle dbg_valid=1 and dbg_ready=0, saturates at STARVE_LIMIT, and clears to 0 on a dbg transfer or when dbg_valid=0.
REQ-019 When starve_cnt==STARVE_LIMIT, priority becomes dbg > ld > alu until the dbg transfer.
REQ-020 On a transfer with rd!=0: next cycle we=1, wa=rd, wd=data (1-cycle latency).
REQ-021 On a transfer with rd==0: the request is consumed (ready high), next cycle we=0.
REQ-022 With no transfer, next cycle we=0; wa/wd hold their previous values.
REQ-023 A registered flag wclr records whether the registered write came from ld or alu (1) or dbg (0).
REQ-024 busy[iss_rd] sets at the edge where iss_valid=1 and iss_rd!=0.
REQ-025 busy[wa] clears at the edge where we=1 and wclr=1, i.e. the same edge the register file commits the data.
REQ-026 If a set and a clear target the same register at the same edge, the set wins and the bit stays 1.
REQ-027 busy[0] is constantly 0.
REQ-028 A dbg write never changes busy.
REQ-029 stall = (rs1!=0 & busy[rs1]) | (rs2!=0 & busy[rs2]), combinational, with no bypass.
REQ-030 Requesters shall hold valid/rd/data stable until their transfer.
REQ-031 The arbiter does not check data against rd.

Reset
REQ-032 While rst=0: we=0, wa=0, wd=0, wclr=0, busy=0, starve_cnt=0, and all ready outputs are 0 regardless of valids.
REQ-033 rst asserted mid-operation aborts any registered write (we=0 immediately) and discards all pending state.
REQ-034 On rst release, arbitration resumes on the first rising edge.

Verification
REQ-035 Simultaneous ld(rd=5, 0xAAAA0001), alu(rd=6, 0xBBBB0002), dbg(rd=7) for 3 cycles -> grant order ld, alu, dbg; we pulses with wa=5, 6, 7 on consecutive cycles.
REQ-036 STARVE_LIMIT=4; ld and alu valid continuously, dbg valid -> dbg_ready=0 for 4 cycles, dbg_ready=1 on the 5th cycle, starve_cnt=0 after.
REQ-037 iss_rd=3, then rs1=3 -> stall=1; alu transfer rd=3 -> stall stays 1 the next cycle (we=1) and drops the cycle after the commit edge.
REQ-038 Same-edge iss_rd=9 and commit wa=9 with wclr=1 -> busy[9] remains 1; with iss_rd=0 -> busy stays 0 and stall=0 for rs1=0.
REQ-039 alu transfer rd=0 -> alu_ready=1, we=0 next cycle, busy unchanged; dbg write rd=4 while busy[4]=1 -> busy[4] stays 1.
REQ-040 rst driven low while we=1 and busy=0x00000108 -> we=0, busy=0, all ready=0 asynchronously; after release, a ld transfer produces we=1 one cycle later.

Source files
------------

// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between the requesters (load, ALU, debug), the issue/decode stage and the arbiter.
// The arbiter connects through the slave modport; the producers connect through the master modport.
interface rf_wb_arbiter_if;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_ready;

  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;

  logic        dbg_valid;
  logic [4:0]  dbg_rd;
  logic [31:0] dbg_data;
  logic        dbg_ready;

  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        stall;

  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [31:0] busy;

  modport master (
    output ld_valid, ld_rd, ld_data,
    output alu_valid, alu_rd, alu_data,
    output dbg_valid, dbg_rd, dbg_data,
    output iss_valid, iss_rd, rs1, rs2,
    input  ld_ready, alu_ready, dbg_ready,
    input  stall, we, wa, wd, busy
  );

  modport slave (
    input  ld_valid, ld_rd, ld_data,
    input  alu_valid, alu_rd, alu_data,
    input  dbg_valid, dbg_rd, dbg_data,
    input  iss_valid, iss_rd, rs1, rs2,
    output ld_ready, alu_ready, dbg_ready,
    output stall, we, wa, wd, busy
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: three requesters share one write port (ld > alu > dbg, with debug
// promoted after starving), plus a pending-writeback scoreboard that stalls decode on busy sources.
module rf_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic            clk,
  input logic            rst,
  rf_wb_arbiter_if.slave bus
);

  localparam int CntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

  logic [CntW-1:0] starveCnt_q, starveCnt_d;
  logic            we_q;
  logic [4:0]      wa_q;
  logic [31:0]     wd_q;
  logic            wclr_q;
  logic [31:0]     busy_q, busy_d;

  logic            dbgPromoted;
  logic            ldGrant, aluGrant, dbgGrant;
  logic [4:0]      selRd;
  logic [31:0]     selData;
  logic            doWrite;

  assign dbgPromoted = (starveCnt_q == StarveMax);

  // Grants are gated by reset so no handshake can complete while the block is held in reset.
  always_comb begin
    ldGrant  = 1'b0;
    aluGrant = 1'b0;
    dbgGrant = 1'b0;
    if (rst) begin
      if (dbgPromoted && bus.dbg_valid) dbgGrant = 1'b1;
      else if (bus.ld_valid)            ldGrant  = 1'b1;
      else if (bus.alu_valid)           aluGrant = 1'b1;
      else if (bus.dbg_valid)           dbgGrant = 1'b1;
    end
  end

  always_comb begin
    selRd   = bus.ld_rd;
    selData = bus.ld_data;
    if (aluGrant) begin
      selRd   = bus.alu_rd;
      selData = bus.alu_data;
    end else if (dbgGrant) begin
      selRd   = bus.dbg_rd;
      selData = bus.dbg_data;
    end
  end

  // A transfer to x0 is consumed but never reaches the register file.
  assign doWrite = (ldGrant | aluGrant | dbgGrant) && (selRd != 5'd0);

  always_comb begin
    starveCnt_d = '0;
    if (bus.dbg_valid && !dbgGrant)
      starveCnt_d = dbgPromoted ? starveCnt_q : starveCnt_q + 1'b1;
  end

  // Issue-set is applied after the commit-clear so a same-edge collision leaves the bit pending.
  always_comb begin
    busy_d = busy_q;
    if (we_q && wclr_q)
      busy_d[wa_q] = 1'b0;
    if (bus.iss_valid && (bus.iss_rd != 5'd0))
      busy_d[bus.iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starveCnt_q <= '0;
      we_q        <= 1'b0;
      wa_q        <= 5'd0;
      wd_q        <= 32'd0;
      wclr_q      <= 1'b0;
      busy_q      <= 32'd0;
    end else begin
      starveCnt_q <= starveCnt_d;
      we_q        <= doWrite;
      busy_q      <= busy_d;
      if (doWrite) begin
        wa_q   <= selRd;
        wd_q   <= selData;
        wclr_q <= !dbgGrant;
      end
    end
  end

  assign bus.ld_ready  = ldGrant;
  assign bus.alu_ready = aluGrant;
  assign bus.dbg_ready = dbgGrant;
  assign bus.we        = we_q;
  assign bus.wa        = wa_q;
  assign bus.wd        = wd_q;
  assign bus.busy      = busy_q;
  assign bus.stall     = ((bus.rs1 != 5'd0) && busy_q[bus.rs1]) ||
                         ((bus.rs2 != 5'd0) && busy_q[bus.rs2]);

endmodule
